// File: rtl/cpu_clk_pkg.sv
// Shared encodings for the CPU clock-enable controller: FSM states, debug modes, phase width.
// Combinational helpers only; no latency, no flow control.
package cpu_clk_pkg;

    localparam logic [1:0] ST_RST_HOLD = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_STEP     = 2'd2;
    localparam logic [1:0] ST_HALT     = 2'd3;

    localparam logic [1:0] MODE_RUN    = 2'd0;
    localparam logic [1:0] MODE_STEP   = 2'd1;
    localparam logic [1:0] MODE_HALT   = 2'd2;

    // Phase register width; a divide-by-1 still keeps a one-bit (constant 0) phase.
    function automatic int pw_of(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/clk_en_divider.sv
// Free-running phase counter 0..DIV-1 with a combinational wrap strobe on the DIV-1 -> 0 edge.
// Wrap is valid in the same cycle phase reads DIV-1; no backpressure, counts every cycle.
module clk_en_divider
    import cpu_clk_pkg::*;
#(
    parameter int DIV = 2,
    parameter int PW  = pw_of(DIV)
) (
    input  logic          clock,
    input  logic          resetn,
    output logic          wrap,
    output logic [PW-1:0] phase
);

    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    assign wrap = (phase == LAST);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            phase <= '0;
        end else if (wrap) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Core clock-enable generator: sequenced core reset, run/step/halt debug modes, retired-cycle count.
// core_en is registered one cycle after the qualifying wrap edge; no backpressure, free-running.
module cpu_clock_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int DIV      = 2,
    parameter int RST_HOLD = 4,
    parameter int CNT_W    = 32,
    localparam int PW      = pw_of(DIV)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [1:0]       mode,
    input  logic             step,
    output logic             core_en,
    output logic             core_resetn,
    output logic [PW-1:0]    phase,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_count
);

    logic       wrap;
    logic [7:0] hold_cnt;
    logic       step_q;
    logic       armed;

    logic [1:0] mode_st;
    logic [1:0] nxt_state;
    logic       step_rise;
    logic       hold_done;
    logic       en_nxt;
    logic       consume;
    logic       armed_nxt;

    clk_en_divider #(
        .DIV (DIV),
        .PW  (PW)
    ) u_div (
        .clock  (clock),
        .resetn (resetn),
        .wrap   (wrap),
        .phase  (phase)
    );

    always_comb begin
        case (mode)
            MODE_RUN:  mode_st = ST_RUN;
            MODE_STEP: mode_st = ST_STEP;
            default:   mode_st = ST_HALT;
        endcase
    end

    assign step_rise = step & ~step_q;
    assign hold_done = (hold_cnt == 8'(RST_HOLD));

    always_comb begin
        nxt_state = state;
        en_nxt    = 1'b0;
        consume   = 1'b0;
        if (state == ST_RST_HOLD) begin
            // The exit edge only releases reset; it never carries a pulse of its own.
            if (hold_done) begin
                nxt_state = mode_st;
            end else begin
                en_nxt = wrap;
            end
        end else if (wrap) begin
            nxt_state = mode_st;
            consume   = (state == ST_STEP) && (mode_st == ST_STEP) && armed;
            en_nxt    = (mode_st == ST_RUN) || consume;
        end

        // A rise on the consuming wrap, or while already armed, is dropped.
        if (nxt_state != ST_STEP) begin
            armed_nxt = 1'b0;
        end else if (consume) begin
            armed_nxt = 1'b0;
        end else begin
            armed_nxt = armed | step_rise;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= ST_RST_HOLD;
            core_en     <= 1'b0;
            core_resetn <= 1'b0;
            hold_cnt    <= 8'd0;
            step_q      <= 1'b0;
            armed       <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= nxt_state;
            core_en     <= en_nxt;
            core_resetn <= (nxt_state != ST_RST_HOLD);
            step_q      <= step;
            armed       <= armed_nxt;
            if (state == ST_RST_HOLD && en_nxt) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
            if (state != ST_RST_HOLD && en_nxt) begin
                cycle_count <= cycle_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Randomised and directed bench for cpu_clock_ctrl over four parameter sets sharing one stimulus.
module tb_cpu_clock_ctrl;

    logic       clock = 1'b0;
    logic       resetn;
    logic [1:0] mode;
    logic       step;

    always #5 clock = ~clock;

    logic        en0, en1, en2, en3;
    logic        rn0, rn1, rn2, rn3;
    logic [0:0]  ph0;
    logic [1:0]  ph1;
    logic [0:0]  ph2;
    logic [0:0]  ph3;
    logic [1:0]  st0, st1, st2, st3;
    logic [31:0] cnt0, cnt1, cnt2;
    logic [3:0]  cnt3;

    cpu_clock_ctrl #(.DIV(2), .RST_HOLD(4), .CNT_W(32)) u0 (
        .clock(clock), .resetn(resetn), .mode(mode), .step(step),
        .core_en(en0), .core_resetn(rn0), .phase(ph0), .state(st0), .cycle_count(cnt0));
    cpu_clock_ctrl #(.DIV(3), .RST_HOLD(2), .CNT_W(32)) u1 (
        .clock(clock), .resetn(resetn), .mode(mode), .step(step),
        .core_en(en1), .core_resetn(rn1), .phase(ph1), .state(st1), .cycle_count(cnt1));
    cpu_clock_ctrl #(.DIV(1), .RST_HOLD(1), .CNT_W(32)) u2 (
        .clock(clock), .resetn(resetn), .mode(mode), .step(step),
        .core_en(en2), .core_resetn(rn2), .phase(ph2), .state(st2), .cycle_count(cnt2));
    cpu_clock_ctrl #(.DIV(2), .RST_HOLD(3), .CNT_W(4)) u3 (
        .clock(clock), .resetn(resetn), .mode(mode), .step(step),
        .core_en(en3), .core_resetn(rn3), .phase(ph3), .state(st3), .cycle_count(cnt3));

    logic [31:0] o_en[4], o_rn[4], o_ph[4], o_st[4], o_cnt[4];
    assign o_en[0] = 32'(en0);  assign o_en[1] = 32'(en1);  assign o_en[2] = 32'(en2);  assign o_en[3] = 32'(en3);
    assign o_rn[0] = 32'(rn0);  assign o_rn[1] = 32'(rn1);  assign o_rn[2] = 32'(rn2);  assign o_rn[3] = 32'(rn3);
    assign o_ph[0] = 32'(ph0);  assign o_ph[1] = 32'(ph1);  assign o_ph[2] = 32'(ph2);  assign o_ph[3] = 32'(ph3);
    assign o_st[0] = 32'(st0);  assign o_st[1] = 32'(st1);  assign o_st[2] = 32'(st2);  assign o_st[3] = 32'(st3);
    assign o_cnt[0] = cnt0;     assign o_cnt[1] = cnt1;     assign o_cnt[2] = cnt2;     assign o_cnt[3] = 32'(cnt3);

    int P_DIV[4] = '{2, 3, 1, 2};
    int P_RH[4]  = '{4, 2, 1, 3};
    int P_CW[4]  = '{32, 32, 32, 4};

    // Reference model: phase as a modular counter, effective mode as the reported state number.
    int     m_ph[4], m_pulses[4], m_eff[4];
    bit     m_hold[4], m_armed[4], m_pstep[4], m_en[4], m_rstn[4];
    longint m_cnt[4];

    int n_chk  = 0;
    int n_pass = 0;
    int edge_n = 0;
    int seen[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp, edge_n);
    endtask

    function automatic int mode_state(input logic [1:0] m);
        return (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : 3;
    endfunction

    task automatic model_step(input int i);
        bit rise, wr, consumed;
        int neweff;
        if (!resetn) begin
            m_ph[i] = 0; m_en[i] = 0; m_rstn[i] = 0; m_hold[i] = 1; m_pulses[i] = 0;
            m_armed[i] = 0; m_pstep[i] = 0; m_cnt[i] = 0; m_eff[i] = 0;
            return;
        end
        rise = step && !m_pstep[i];
        m_pstep[i] = step;
        wr = (m_ph[i] == P_DIV[i] - 1);
        m_ph[i] = wr ? 0 : m_ph[i] + 1;
        m_en[i] = 0;
        consumed = 0;
        if (m_hold[i]) begin
            if (m_pulses[i] == P_RH[i]) begin
                m_hold[i] = 0; m_rstn[i] = 1; m_eff[i] = mode_state(mode);
            end else if (wr) begin
                m_en[i] = 1; m_pulses[i]++;
            end
        end else if (wr) begin
            neweff = mode_state(mode);
            if (neweff == 1) m_en[i] = 1;
            else if (neweff == 2 && m_armed[i]) begin
                m_en[i] = 1; m_armed[i] = 0; consumed = 1;
            end
            if (neweff != 2) m_armed[i] = 0;
            m_eff[i] = neweff;
        end
        if (!m_hold[i] && m_eff[i] == 2 && rise && !consumed) m_armed[i] = 1;
        if (m_en[i] && !m_hold[i]) m_cnt[i] = (m_cnt[i] + 1) & ((64'd1 << P_CW[i]) - 1);
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("i%0d core_en", i), o_en[i], 32'(m_en[i]));
            chk($sformatf("i%0d core_resetn", i), o_rn[i], 32'(m_rstn[i]));
            chk($sformatf("i%0d state", i), o_st[i], m_hold[i] ? 32'd0 : 32'(m_eff[i]));
            chk($sformatf("i%0d phase", i), o_ph[i], 32'(m_ph[i]));
            chk($sformatf("i%0d cycle_count", i), o_cnt[i], m_cnt[i][31:0]);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        for (int i = 0; i < 4; i++) model_step(i);
        @(negedge clock);
        edge_n++;
        check_all();
        for (int i = 0; i < 4; i++) if (o_en[i][0]) seen[i]++;
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 4; i++) seen[i] = 0;
    endtask

    initial begin
        int base;
        int guard;
        resetn = 1'b0; mode = 2'd0; step = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) chk($sformatf("i%0d reset state", i), o_st[i], 32'd0);

        // Power-up sequence: explicit edge-numbered expectations.
        resetn = 1'b1;
        edge_n = 0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            chk("seq i0 en", o_en[0], 32'((e % 2) == 0));
            chk("seq i0 resetn", o_rn[0], 32'(e >= 9));
            chk("seq i2 en", o_en[2], 32'(e != 2));
            chk("seq i2 resetn", o_rn[2], 32'(e >= 2));
            chk("seq i1 phase", o_ph[1], 32'(e % 3));
            if (e == 8)  chk("seq i0 cnt@8", o_cnt[0], 32'd0);
            if (e == 10) chk("seq i0 cnt@10", o_cnt[0], 32'd1);
            if (e == 37) chk("run i1 cnt@37", o_cnt[1], 32'd10);
            if (e == 36) chk("i3 cnt 15", o_cnt[3], 32'd15);
            if (e == 38) chk("i3 cnt wrap", o_cnt[3], 32'd0);
        end

        // Single-step: three well-spaced requests.
        mode = 2'd1;
        repeat (5) tick();
        clear_seen();
        base = o_cnt[0];
        for (int k = 0; k < 3; k++) begin
            step = 1'b1; tick();
            step = 1'b0; repeat (9) tick();
        end
        for (int i = 0; i < 4; i++) chk($sformatf("i%0d step pulses", i), 32'(seen[i]), 32'd3);
        chk("step i0 cnt delta", o_cnt[0] - 32'(base), 32'd3);

        // Two rises inside one DIV=3 window, first one on a wrap edge.
        guard = 0;
        while (m_ph[1] != 2 && guard < 10) begin tick(); guard++; end
        clear_seen();
        step = 1'b1; tick();
        step = 1'b0; tick();
        step = 1'b1; tick();
        step = 1'b0; repeat (6) tick();
        chk("double step i1", 32'(seen[1]), 32'd1);

        // Halt then resume.
        mode = 2'd2;
        repeat (4) tick();
        clear_seen();
        repeat (10) tick();
        for (int i = 0; i < 4; i++) chk($sformatf("i%0d halt pulses", i), 32'(seen[i]), 32'd0);
        mode = 2'd0;
        clear_seen();
        repeat (6) tick();
        chk("resume i0", 32'(seen[0]), 32'd3);
        chk("resume i1", 32'(seen[1]), 32'd2);
        chk("resume i2", 32'(seen[2]), 32'd6);
        chk("resume i3", 32'(seen[3]), 32'd3);

        // Mid-run reset at cycle_count 57.
        guard = 0;
        while (m_cnt[0] != 57 && guard < 400) begin tick(); guard++; end
        chk("reach 57", o_cnt[0], 32'd57);
        resetn = 1'b0;
        tick();
        chk("mid rst en", o_en[0], 32'd0);
        chk("mid rst resetn", o_rn[0], 32'd0);
        chk("mid rst state", o_st[0], 32'd0);
        chk("mid rst phase", o_ph[0], 32'd0);
        chk("mid rst cnt", o_cnt[0], 32'd0);
        resetn = 1'b1;
        repeat (10) tick();
        chk("replay i0 resetn", o_rn[0], 32'd1);
        chk("replay i0 cnt", o_cnt[0], 32'd1);

        // Random traffic against the model.
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            step   = ($urandom_range(0, 3) == 0);
            resetn = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
